// File: rtl/rx_uart.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling driven by an
// external oversample strobe, optional even/odd parity check and stop-bit
// framing check. Each word is presented with a one-cycle o_valid pulse and
// held, together with its status flags, until the next word arrives.
module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = 0,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_parity_err,
  output logic                        o_framing_err,
  output logic                        o_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(INPUT_DATA_WIDTH + 1);

  // Last tick index of half a bit (start-bit centre) and of a full bit.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(INPUT_DATA_WIDTH - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);
  localparam logic              PAR_EN    = (PARITY_ENABLED != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic                        rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]           tick_q, tick_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                        perr_q, perr_d;
  logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        operr_q, operr_d;
  logic                        oferr_q, oferr_d;
  logic                        busy_q;

  // Next-state logic: counters and sampling only move on sample_tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    operr_d = operr_q;
    oferr_d = oferr_q;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == HALF_LAST) begin
            tick_d = '0;
            if (!rx_s_q) begin
              state_d = DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
            end else begin
              // Start bit did not survive to its centre: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[INPUT_DATA_WIDTH-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = PAR_EN ? PARITY : STOP;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        PARITY: begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            perr_d  = ((^shift_q) ^ rx_s_q) != ODD;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_q == FULL_LAST) begin
            // Return to IDLE at mid-stop so a back-to-back start edge is caught.
            tick_d  = '0;
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
            operr_d = PAR_EN & perr_q;
            oferr_d = ~rx_s_q;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // Synchroniser, FSM state, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      operr_q   <= 1'b0;
      oferr_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      operr_q   <= operr_d;
      oferr_q   <= oferr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_parity_err  = operr_q;
  assign o_framing_err = oferr_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: three instances (even parity, odd parity,
// no parity) each on its own serial line, sharing clock, strobe and reset.
// sample_tick pulses every second clock cycle, OVERSAMPLE = 16.
module tb_rx_uart;

  logic clk = 1'b0;
  logic reset;
  logic sample_tick;
  logic tdiv;
  logic ser_e, ser_o, ser_n;

  logic [7:0] data_e, data_o, data_n;
  logic valid_e, valid_o, valid_n;
  logic perr_e, perr_o, perr_n;
  logic ferr_e, ferr_o, ferr_n;
  logic busy_e, busy_o, busy_n;

  int n_chk  = 0;
  int n_pass = 0;
  logic busy_mid;

  logic [9:0] q_e[$];
  logic [9:0] q_o[$];
  logic [9:0] q_n[$];

  rx_uart #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_ODD(0), .OVERSAMPLE(16)) u_even (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .serial_in(ser_e),
    .o_data(data_e), .o_valid(valid_e), .o_parity_err(perr_e),
    .o_framing_err(ferr_e), .o_busy(busy_e));

  rx_uart #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_ODD(1), .OVERSAMPLE(16)) u_odd (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .serial_in(ser_o),
    .o_data(data_o), .o_valid(valid_o), .o_parity_err(perr_o),
    .o_framing_err(ferr_o), .o_busy(busy_o));

  rx_uart #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0), .PARITY_ODD(0), .OVERSAMPLE(16)) u_nopar (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .serial_in(ser_n),
    .o_data(data_n), .o_valid(valid_n), .o_parity_err(perr_n),
    .o_framing_err(ferr_n), .o_busy(busy_n));

  always #5 clk = ~clk;

  initial begin
    tdiv = 1'b0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = ~tdiv;
      sample_tick = tdiv;
    end
  end

  // Capture every received word as {parity_err, framing_err, data}.
  always @(negedge clk) begin
    if (valid_e) q_e.push_back({perr_e, ferr_e, data_e});
    if (valid_o) q_o.push_back({perr_o, ferr_o, data_o});
    if (valid_n) q_n.push_back({perr_n, ferr_n, data_n});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (sample_tick !== 1'b1);
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: ser_e = v;
      1: ser_o = v;
      default: ser_n = v;
    endcase
  endtask

  task automatic send_bit(input int which, input logic v);
    @(negedge clk);
    set_line(which, v);
    repeat (16) wait_tick();
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit);
    send_bit(which, 1'b0);
    @(negedge clk);
    busy_mid = (which == 0) ? busy_e : (which == 1) ? busy_o : busy_n;
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    if (pen) send_bit(which, pbit);
    send_bit(which, sbit);
  endtask

  task automatic expect_frame(input string tag, input int which, input logic [7:0] d,
                              input logic pe, input logic fe);
    logic [9:0] v;
    int sz;
    sz = (which == 0) ? q_e.size() : (which == 1) ? q_o.size() : q_n.size();
    check_eq({tag, "_present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (which == 0) v = q_e.pop_front();
      else if (which == 1) v = q_o.pop_front();
      else v = q_n.pop_front();
      check_eq({tag, "_data"}, 32'(v[7:0]), 32'(d));
      check_eq({tag, "_perr"}, 32'(v[9]), 32'(pe));
      check_eq({tag, "_ferr"}, 32'(v[8]), 32'(fe));
    end
  endtask

  initial begin
    int rise;
    int fall;
    reset = 1'b1;
    ser_e = 1'b1;
    ser_o = 1'b1;
    ser_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_data",  32'(data_e),  32'h0);
    check_eq("rst_valid", 32'(valid_e), 32'h0);
    check_eq("rst_perr",  32'(perr_e),  32'h0);
    check_eq("rst_ferr",  32'(ferr_e),  32'h0);
    check_eq("rst_busy",  32'(busy_e),  32'h0);
    reset = 1'b0;
    repeat (10) wait_tick();

    // Nominal even-parity frame.
    @(negedge clk);
    check_eq("t1_idle_busy", 32'(busy_e), 32'h0);
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    check_eq("t1_busy_mid", 32'(busy_mid), 32'h1);
    @(negedge clk);
    check_eq("t1_busy_end", 32'(busy_e), 32'h0);
    expect_frame("t1", 0, 8'hA5, 1'b0, 1'b0);
    check_eq("t1_single", 32'(q_e.size()), 32'h0);

    // Parity error in even mode; same bits accepted in odd mode.
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
    expect_frame("t2_even", 0, 8'h3C, 1'b1, 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    expect_frame("t2_odd", 1, 8'h3C, 1'b0, 1'b0);
    check_eq("t2_hold_data", 32'(data_e), 32'h3C);
    check_eq("t2_hold_perr", 32'(perr_e), 32'h1);
    check_eq("t2_no_extra", 32'(q_e.size()), 32'h0);

    // Framing error, then keep the line low (break) for about three frames.
    send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0);
    repeat (505) wait_tick();
    @(negedge clk);
    set_line(0, 1'b1);
    repeat (200) wait_tick();
    expect_frame("t3_frm", 0, 8'h55, 1'b0, 1'b1);
    expect_frame("t3_brk0", 0, 8'h00, 1'b0, 1'b1);
    expect_frame("t3_brk1", 0, 8'h00, 1'b0, 1'b1);
    expect_frame("t3_brk2", 0, 8'h00, 1'b0, 1'b1);
    check_eq("t3_count", 32'(q_e.size()), 32'h0);

    // Glitch: line low for 4 ticks only.
    rise = -1;
    fall = -1;
    @(negedge clk);
    set_line(0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      wait_tick();
      @(negedge clk);
      if (k == 4) set_line(0, 1'b1);
      if (busy_e && rise < 0) rise = k;
      if (!busy_e && rise >= 0 && fall < 0) fall = k;
    end
    check_eq("t4_busy_rose", 32'(rise >= 0), 32'h1);
    check_eq("t4_busy_fell", 32'(fall >= 0), 32'h1);
    check_eq("t4_busy_span", 32'(fall - rise), 32'd8);
    check_eq("t4_no_valid", 32'(q_e.size()), 32'h0);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(0, 8'h80, 1'b1, 1'b1, 1'b1);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b1);
    expect_frame("t5_a", 0, 8'h01, 1'b0, 1'b0);
    expect_frame("t5_b", 0, 8'h80, 1'b0, 1'b0);
    expect_frame("t5_c", 0, 8'hFF, 1'b0, 1'b0);
    check_eq("t5_count", 32'(q_e.size()), 32'h0);

    // Reset part-way through the data bits of 0x42.
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    @(negedge clk);
    check_eq("t6_busy_pre", 32'(busy_e), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_line(0, 1'b1);
    check_eq("t6_rst_data",  32'(data_e),  32'h0);
    check_eq("t6_rst_valid", 32'(valid_e), 32'h0);
    check_eq("t6_rst_perr",  32'(perr_e),  32'h0);
    check_eq("t6_rst_ferr",  32'(ferr_e),  32'h0);
    check_eq("t6_rst_busy",  32'(busy_e),  32'h0);
    repeat (200) wait_tick();
    check_eq("t6_aborted", 32'(q_e.size()), 32'h0);
    send_frame(0, 8'h42, 1'b1, 1'b0, 1'b1);
    expect_frame("t6_rx", 0, 8'h42, 1'b0, 1'b0);

    // No-parity variant: 10-bit frame.
    send_frame(2, 8'hA5, 1'b0, 1'b0, 1'b1);
    expect_frame("t6_nopar", 2, 8'hA5, 1'b0, 1'b0);
    check_eq("t6_nopar_count", 32'(q_n.size()), 32'h0);
    check_eq("t6_odd_count", 32'(q_o.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
UART receiver paired with the team's UART transmitter. It accepts the same frame: 1 start bit (0), INPUT_DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1). The line is oversampled by an external one-cycle enable strobe. Each received word is presented for one clk cycle together with parity and framing status, for a downstream FIFO or register file.

Parameters:
INPUT_DATA_WIDTH, 8, number of data bits per frame
PARITY_ENABLED, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity (data bits plus parity bit have an even count of ones); 1 = odd parity
OVERSAMPLE, 16, sample_tick pulses per bit period; must be an even number ≥ 4

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
sample_tick  input  1  one-clk-cycle enable at OVERSAMPLE × baud rate
serial_in  input  1  asynchronous serial line; idles at 1
o_data  output  INPUT_DATA_WIDTH  received data word, LSB = first bit received
o_valid  output  1  one-cycle pulse: o_data and the error flags are valid
o_parity_err  output  1  parity mismatch for the current o_data; always 0 when PARITY_ENABLED=0
o_framing_err  output  1  stop bit sampled as 0 for the current o_data
o_busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Input synchroniser
  - serial_in passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses only the synchronised signal rx_s.
- Reset values
  - o_data=0, o_valid=0, o_parity_err=0, o_framing_err=0, o_busy=0.
  - FSM=IDLE; tick counter and bit counter = 0.
- The tick counter and the bit counter advance only on clk cycles where sample_tick=1.
- FSM states and transitions
  - IDLE: on sample_tick with rx_s=0, go to START and clear the tick counter.
  - START: count OVERSAMPLE/2 ticks to reach the middle of the start bit. At that tick:
    - rx_s=0: go to DATA; clear the tick counter and the bit counter.
    - rx_s=1: false start; return to IDLE. No o_valid, no error flags.
  - DATA: every OVERSAMPLE ticks, sample rx_s into the shift register MSB side and shift right, so the first bit received lands in bit 0. After INPUT_DATA_WIDTH samples, go to PARITY if PARITY_ENABLED=1, otherwise to STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit.
    - parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
  - STOP: after OVERSAMPLE ticks, sample the stop bit.
    - framing_err = ~rx_s.
    - Go to IDLE.
- Output timing
  - On the clk cycle after the stop-bit sample, o_valid=1 for exactly one cycle.
  - In that same cycle o_data, o_parity_err and o_framing_err are updated. They hold their values until the next o_valid.
  - o_valid is asserted even when errors are flagged.
- Back-to-back frames
  - The FSM returns to IDLE immediately after the stop-bit sample.
  - A start edge on the next sample_tick is detected, so frames with a single stop bit and no gap are received without loss.
- Break condition (line held at 0)
  - Produces a frame with o_data=0 and o_framing_err=1.
  - The FSM then re-enters START on the next tick, because rx_s is still 0.
- sample_tick gaps: sample_tick=0 freezes all counters. No timeout exists.
- Reset mid-frame
  - Returns to IDLE within one cycle with all outputs at their reset values.
  - No o_valid is produced for the aborted frame.
- o_busy = (state != IDLE), registered together with the state.

Test Plan:
1. Nominal even parity: OVERSAMPLE=16, send 0xA5 with parity bit 0 and stop 1 -> one o_valid pulse, o_data=0xA5, o_parity_err=0, o_framing_err=0; o_busy high from the start-edge detect until the stop sample.
2. Parity error: send 0x3C with parity bit 1 (even mode) -> o_data=0x3C, o_parity_err=1, o_framing_err=0. Repeat with PARITY_ODD=1 and parity bit 1 -> o_parity_err=0.
3. Framing error and break: send 0x55 with stop bit 0 -> o_framing_err=1, o_data=0x55. Then hold the line at 0 for 3 frame times -> repeated frames with o_data=0x00, o_framing_err=1.
4. Glitch rejection: drive serial_in low for 4 ticks, then high -> no o_valid; o_busy returns to 0 at the 8th tick.
5. Back-to-back frames: send 0x01, 0x80, 0xFF consecutively with no idle gap -> exactly three o_valid pulses, in that order, with no error flags.
6. Reset and no-parity variant: assert reset for 1 cycle mid-way through the DATA bits of 0x42 -> no o_valid and outputs at reset values; the next frame 0x42 is received correctly. Repeat test 1 with PARITY_ENABLED=0 (frame of 10 bits) -> o_data=0xA5, o_parity_err=0.
